// File: rtl/hog_pkg.sv
// hog_pkg: shared constants, FSM state encoding and the corner-skipping
// window walk used by the HOG cell fetcher.
package hog_pkg;

    localparam int PIX_W  = 8;
    localparam int CELL_S = 10;
    localparam int PIX_N  = CELL_S * CELL_S - 4;
    localparam int IN_W   = PIX_W * PIX_N;
    localparam int K_W    = $clog2(PIX_N + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_DRAIN,
        S_DONE
    } fsm_t;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] c;
    } rc_t;

    // Slot k -> (r,c) in the 10x10 window, row-major, corners skipped.
    // Row 0 loses one corner before it, rows 1..8 two, row 9 three.
    function automatic rc_t k_to_rc(input logic [K_W-1:0] k);
        logic [K_W-1:0] j;
        rc_t            rc;
        if (k < K_W'(CELL_S - 2))
            j = k + K_W'(1);
        else if (k < K_W'(CELL_S * (CELL_S - 1) - 2))
            j = k + K_W'(2);
        else
            j = k + K_W'(3);
        rc.r = 4'(j / K_W'(CELL_S));
        rc.c = 4'(j % K_W'(CELL_S));
        return rc;
    endfunction

endpackage

// File: rtl/hog_cell_fetch_if.sv
// hog_cell_fetch_if: request/ready cell bus plus pixel memory port.
// slave = fetcher side, master = consumer/memory side.
interface hog_cell_fetch_if #(
    parameter int IMG_W = 320,
    parameter int IMG_H = 240
);
    import hog_pkg::*;

    localparam int CX_W   = $clog2(IMG_W / 8);
    localparam int CY_W   = $clog2(IMG_H / 8);
    localparam int ADDR_W = $clog2(IMG_W * IMG_H);

    logic              i_start;
    logic              request;
    logic              ready;
    logic [IN_W-1:0]   o_data_fetch;
    logic [CX_W-1:0]   o_cell_x;
    logic [CY_W-1:0]   o_cell_y;
    logic              o_frame_done;
    logic              mem_re;
    logic [ADDR_W-1:0] mem_addr;
    logic [PIX_W-1:0]  mem_rdata;

    modport slave (
        input  i_start, request, mem_rdata,
        output ready, o_data_fetch, o_cell_x, o_cell_y,
        output o_frame_done, mem_re, mem_addr
    );

    modport master (
        output i_start, request, mem_rdata,
        input  ready, o_data_fetch, o_cell_x, o_cell_y,
        input  o_frame_done, mem_re, mem_addr
    );

endinterface

// File: rtl/hog_cell_addr_gen.sv
// hog_cell_addr_gen: maps (cx,cy,r,c) to a row-major pixel address and
// an in-range flag. Ports: cx_i, cy_i, r_i, c_i -> addr_o, in_range_o.
// HOG_CELL_FETCH_EDGE_CLAMP_EN: clamp to the frame, always in range.
module hog_cell_addr_gen #(
    parameter int IMG_W  = 320,
    parameter int IMG_H  = 240,
    parameter int CX_W   = $clog2(IMG_W / 8),
    parameter int CY_W   = $clog2(IMG_H / 8),
    parameter int ADDR_W = $clog2(IMG_W * IMG_H)
) (
    input  logic [CX_W-1:0]   cx_i,
    input  logic [CY_W-1:0]   cy_i,
    input  logic [3:0]        r_i,
    input  logic [3:0]        c_i,
    output logic [ADDR_W-1:0] addr_o,
    output logic              in_range_o
);

    // Two spare bits: one for the -1 border, one for sign.
    localparam int XW = $clog2(IMG_W) + 2;
    localparam int YW = $clog2(IMG_H) + 2;

    logic signed [XW-1:0] x_s;
    logic signed [XW-1:0] x_c;
    logic signed [YW-1:0] y_s;
    logic signed [YW-1:0] y_c;
    logic                 x_ok;
    logic                 y_ok;

    always_comb begin
        x_s = $signed(XW'({cx_i, 3'b000})) + $signed(XW'(c_i))
            - $signed(XW'(1));
        y_s = $signed(YW'({cy_i, 3'b000})) + $signed(YW'(r_i))
            - $signed(YW'(1));
        x_ok = !x_s[XW-1] && (x_s < $signed(XW'(IMG_W)));
        y_ok = !y_s[YW-1] && (y_s < $signed(YW'(IMG_H)));
`ifdef HOG_CELL_FETCH_EDGE_CLAMP_EN
        x_c = x_s[XW-1] ? '0 : (x_ok ? x_s : $signed(XW'(IMG_W - 1)));
        y_c = y_s[YW-1] ? '0 : (y_ok ? y_s : $signed(YW'(IMG_H - 1)));
        in_range_o = 1'b1;
`else
        x_c = x_s;
        y_c = y_s;
        in_range_o = x_ok && y_ok;
`endif
        addr_o = ADDR_W'(unsigned'(y_c)) * ADDR_W'(IMG_W)
               + ADDR_W'(unsigned'(x_c));
    end

endmodule

// File: rtl/hog_cell_fetch.sv
// hog_cell_fetch: serves 96-pixel bordered cells in raster order.
// Ports: clk, rst (sync, high), bus (slave): i_start, request, ready,
// o_data_fetch, o_cell_x/y, o_frame_done, mem_re/addr/rdata.
// HOG_CELL_FETCH_EDGE_CLAMP_EN selects edge clamp instead of zero pad.
module hog_cell_fetch
    import hog_pkg::*;
#(
    parameter int IMG_W = 320,
    parameter int IMG_H = 240
) (
    input logic             clk,
    input logic             rst,
    hog_cell_fetch_if.slave bus
);

    localparam int CELL_X = IMG_W / 8;
    localparam int CELL_Y = IMG_H / 8;
    localparam int CX_W   = $clog2(CELL_X);
    localparam int CY_W   = $clog2(CELL_Y);
    localparam int ADDR_W = $clog2(IMG_W * IMG_H);

    fsm_t              state_q, state_d;
    logic [K_W-1:0]    k_q, k_d;
    logic [CX_W-1:0]   ptr_x_q, ptr_x_d;
    logic [CY_W-1:0]   ptr_y_q, ptr_y_d;
    logic [CX_W-1:0]   lat_x_q, lat_x_d;
    logic [CY_W-1:0]   lat_y_q, lat_y_d;
    logic              start_pend_q, start_pend_d;
    logic              re_q, re_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              pend_v_q;
    logic              pend_rd_q;
    logic [IN_W-1:0]   asm_q;
    logic [IN_W-1:0]   out_q;
    logic [IN_W-1:0]   shifted;
    logic [CX_W-1:0]   cell_x_q;
    logic [CY_W-1:0]   cell_y_q;
    logic              ready_q;
    logic              fdone_q;
    logic              last_cell;

    logic [CX_W-1:0]   g_cx;
    logic [CY_W-1:0]   g_cy;
    logic [K_W-1:0]    g_k;
    rc_t               g_rc;
    logic [ADDR_W-1:0] g_addr;
    logic              g_ok;

    // Address for the slot driven in the next cycle: slot 0 of the
    // cell being latched in IDLE, else slot k+1 of the latched cell.
    always_comb begin
        if (state_q == S_IDLE) begin
            g_cx = bus.i_start ? '0 : ptr_x_q;
            g_cy = bus.i_start ? '0 : ptr_y_q;
            g_k  = '0;
        end else begin
            g_cx = lat_x_q;
            g_cy = lat_y_q;
            g_k  = k_q + K_W'(1);
        end
        g_rc = k_to_rc(g_k);
    end

    hog_cell_addr_gen #(
        .IMG_W (IMG_W),
        .IMG_H (IMG_H),
        .CX_W  (CX_W),
        .CY_W  (CY_W),
        .ADDR_W(ADDR_W)
    ) u_addr (
        .cx_i      (g_cx),
        .cy_i      (g_cy),
        .r_i       (g_rc.r),
        .c_i       (g_rc.c),
        .addr_o    (g_addr),
        .in_range_o(g_ok)
    );

    assign last_cell = (lat_x_q == CX_W'(CELL_X - 1))
                    && (lat_y_q == CY_W'(CELL_Y - 1));

    // Shift-in of the returning datum; slots not read arrive as zero.
    assign shifted = {pend_rd_q ? bus.mem_rdata : '0,
                      asm_q[IN_W-1:PIX_W]};

    always_comb begin
        state_d      = state_q;
        k_d          = k_q;
        ptr_x_d      = ptr_x_q;
        ptr_y_d      = ptr_y_q;
        lat_x_d      = lat_x_q;
        lat_y_d      = lat_y_q;
        start_pend_d = start_pend_q;
        re_d         = 1'b0;
        addr_d       = addr_q;
        unique case (state_q)
            S_IDLE: begin
                if (bus.request) begin
                    state_d = S_FETCH;
                    k_d     = '0;
                    lat_x_d = g_cx;
                    lat_y_d = g_cy;
                    re_d    = g_ok;
                    if (g_ok)
                        addr_d = g_addr;
                end
            end
            S_FETCH: begin
                if (bus.i_start)
                    start_pend_d = 1'b1;
                if (k_q == K_W'(PIX_N - 1)) begin
                    state_d = S_DRAIN;
                end else begin
                    k_d  = k_q + K_W'(1);
                    re_d = g_ok;
                    if (g_ok)
                        addr_d = g_addr;
                end
            end
            S_DRAIN: begin
                state_d      = S_DONE;
                start_pend_d = 1'b0;
                if (start_pend_q) begin
                    ptr_x_d = '0;
                    ptr_y_d = '0;
                end else if (lat_x_q == CX_W'(CELL_X - 1)) begin
                    ptr_x_d = '0;
                    ptr_y_d = (lat_y_q == CY_W'(CELL_Y - 1)) ? '0
                            : lat_y_q + CY_W'(1);
                end else begin
                    ptr_x_d = lat_x_q + CX_W'(1);
                    ptr_y_d = lat_y_q;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        // A new frame always wins over the post-delivery advance.
        if (bus.i_start) begin
            ptr_x_d = '0;
            ptr_y_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            k_q          <= '0;
            ptr_x_q      <= '0;
            ptr_y_q      <= '0;
            lat_x_q      <= '0;
            lat_y_q      <= '0;
            start_pend_q <= 1'b0;
            re_q         <= 1'b0;
            addr_q       <= '0;
            pend_v_q     <= 1'b0;
            pend_rd_q    <= 1'b0;
            asm_q        <= '0;
            out_q        <= '0;
            cell_x_q     <= '0;
            cell_y_q     <= '0;
            ready_q      <= 1'b0;
            fdone_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            k_q          <= k_d;
            ptr_x_q      <= ptr_x_d;
            ptr_y_q      <= ptr_y_d;
            lat_x_q      <= lat_x_d;
            lat_y_q      <= lat_y_d;
            start_pend_q <= start_pend_d;
            re_q         <= re_d;
            addr_q       <= addr_d;
            // Slot flag follows the one-cycle memory latency.
            pend_v_q     <= (state_q == S_FETCH);
            pend_rd_q    <= re_q;
            if (pend_v_q)
                asm_q <= shifted;
            // Last datum lands in DRAIN; publish it with the cell.
            ready_q <= (state_q == S_DRAIN);
            fdone_q <= (state_q == S_DRAIN) && last_cell;
            if (state_q == S_DRAIN) begin
                out_q    <= shifted;
                cell_x_q <= lat_x_q;
                cell_y_q <= lat_y_q;
            end
        end
    end

    assign bus.ready        = ready_q;
    assign bus.o_data_fetch = out_q;
    assign bus.o_cell_x     = cell_x_q;
    assign bus.o_cell_y     = cell_y_q;
    assign bus.o_frame_done = fdone_q;
    assign bus.mem_re       = re_q;
    assign bus.mem_addr     = addr_q;

endmodule

// File: tb/tb_hog_cell_fetch.sv
// tb_hog_cell_fetch: scoreboard bench for hog_cell_fetch with a
// behavioural window model and a (x + 3y) mod 256 pixel memory.
module tb_hog_cell_fetch;
    import hog_pkg::*;

    // Small frame so a full-frame wrap fits a short run.
    localparam int IMG_W  = 64;
    localparam int IMG_H  = 48;
    localparam int CELL_X = IMG_W / 8;
    localparam int CELL_Y = IMG_H / 8;

    logic clk = 1'b0;
    logic rst = 1'b1;

    hog_cell_fetch_if #(.IMG_W(IMG_W), .IMG_H(IMG_H)) bus ();

    hog_cell_fetch #(.IMG_W(IMG_W), .IMG_H(IMG_H)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [IN_W-1:0] data;
        int              cx;
        int              cy;
        bit              fd;
        int              edge_n;
        int              reads;
    } exp_t;

    exp_t q[$];
    int   mx = 0;
    int   my = 0;

    // Pixel memory: one-cycle read; junk when no read was issued.
    always @(posedge clk) begin
        int a;
        a = int'(bus.mem_addr);
        bus.mem_rdata <= bus.mem_re
            ? 8'(((a % IMG_W) + 3 * (a / IMG_W)) % 256)
            : 8'($urandom);
    end

    task automatic chk(input string name, input logic [IN_W-1:0] act,
                       input logic [IN_W-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endtask

    function automatic void model(input int cx, input int cy,
                                  output logic [IN_W-1:0] d,
                                  output int reads);
        int k;
        k = 0;
        d = '0;
        reads = 0;
        for (int r = 0; r < CELL_S; r++) begin
            for (int c = 0; c < CELL_S; c++) begin
                int x;
                int y;
                bit corner;
                corner = (r == 0 || r == CELL_S - 1)
                      && (c == 0 || c == CELL_S - 1);
                if (!corner) begin
                    x = cx * 8 + c - 1;
                    y = cy * 8 + r - 1;
`ifdef HOG_CELL_FETCH_EDGE_CLAMP_EN
                    if (x < 0) x = 0;
                    if (x > IMG_W - 1) x = IMG_W - 1;
                    if (y < 0) y = 0;
                    if (y > IMG_H - 1) y = IMG_H - 1;
                    d[k*PIX_W +: PIX_W] = 8'((x + 3 * y) % 256);
                    reads++;
`else
                    if (x >= 0 && x < IMG_W && y >= 0 && y < IMG_H) begin
                        d[k*PIX_W +: PIX_W] = 8'((x + 3 * y) % 256);
                        reads++;
                    end
`endif
                    k++;
                end
            end
        end
    endfunction

    function automatic void push_cell(input int edge_n);
        exp_t e;
        model(mx, my, e.data, e.reads);
        e.cx     = mx;
        e.cy     = my;
        e.fd     = (mx == CELL_X - 1) && (my == CELL_Y - 1);
        e.edge_n = edge_n;
        q.push_back(e);
        if (mx == CELL_X - 1) begin
            mx = 0;
            my = (my == CELL_Y - 1) ? 0 : my + 1;
        end else begin
            mx++;
        end
    endfunction

    // Monitor: ready appears in the cycle opening at edge E+PIX_N+1.
    int rd_cnt = 0;
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            rd_cnt = 0;
        end else if (bus.ready) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_ready: pulse at edge %0d, required none",
                         cyc);
            end else begin
                e = q.pop_front();
                chk("data", bus.o_data_fetch, e.data);
                chk("cell_x", IN_W'(bus.o_cell_x), IN_W'(e.cx));
                chk("cell_y", IN_W'(bus.o_cell_y), IN_W'(e.cy));
                chk("frame_done", IN_W'(bus.o_frame_done), IN_W'(e.fd));
                chk("ready_edge", IN_W'(cyc), IN_W'(e.edge_n));
                chk("read_count", IN_W'(rd_cnt), IN_W'(e.reads));
            end
            rd_cnt = 0;
        end else if (bus.mem_re) begin
            rd_cnt++;
        end
    end

    task automatic check_reset(input string tag);
        chk({tag, "_ready"}, IN_W'(bus.ready), '0);
        chk({tag, "_data"}, bus.o_data_fetch, '0);
        chk({tag, "_cell_x"}, IN_W'(bus.o_cell_x), '0);
        chk({tag, "_cell_y"}, IN_W'(bus.o_cell_y), '0);
        chk({tag, "_frame_done"}, IN_W'(bus.o_frame_done), '0);
        chk({tag, "_mem_re"}, IN_W'(bus.mem_re), '0);
        chk({tag, "_mem_addr"}, IN_W'(bus.mem_addr), '0);
    endtask

    // Hold request for n deliveries; optional i_start with the request
    // or one pulse in the middle of the fetch.
    task automatic run_cells(input int n, input bit with_start,
                             input bit mid_start);
        int e0;
        int got;
        int t;
        int lim;
        repeat (1 + $urandom_range(0, 3)) @(negedge clk);
        bus.request = 1'b1;
        bus.i_start = with_start;
        e0 = cyc + 1;
        if (with_start) begin
            mx = 0;
            my = 0;
        end
        for (int i = 0; i < n; i++)
            push_cell(e0 + i * (PIX_N + 3) + PIX_N + 1);
        if (mid_start) begin
            mx = 0;
            my = 0;
        end
        got = 0;
        t   = 0;
        lim = n * (PIX_N + 3) + 20;
        while (got < n && t < lim) begin
            @(negedge clk);
            t++;
            bus.i_start = mid_start && (t == 30);
            if (bus.ready) got++;
        end
        bus.request = 1'b0;
        bus.i_start = 1'b0;
        if (got < n) begin
            checks++;
            errors++;
            $display("FAIL timeout: got %0d ready pulses, required %0d", got, n);
            q.delete();
        end
    endtask

    task automatic reset_mid_fetch();
        int e0;
        repeat (2) @(negedge clk);
        bus.request = 1'b1;
        e0 = cyc + 1;
        @(negedge clk);
        bus.request = 1'b0;
        while (cyc < e0 + 49) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_reset("mid_reset");
        rst = 1'b0;
        mx = 0;
        my = 0;
        repeat (120) @(negedge clk);
    endtask

    initial begin
        bus.request = 1'b0;
        bus.i_start = 1'b0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_reset("reset");
        rst = 1'b0;
        run_cells(1, 1'b0, 1'b0);
        run_cells(40, 1'b0, 1'b0);
        run_cells(7, 1'b0, 1'b0);
        run_cells(1, 1'b0, 1'b0);
        run_cells(2, 1'b0, 1'b0);
        reset_mid_fetch();
        run_cells(1, 1'b0, 1'b0);
        run_cells(22, 1'b0, 1'b0);
        run_cells(1, 1'b1, 1'b0);
        run_cells(1, 1'b0, 1'b1);
        run_cells(1, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++)
            run_cells($urandom_range(1, 3), $urandom_range(0, 4) == 0, 1'b0);
        repeat (10) @(negedge clk);
        chk("queue_empty", IN_W'(q.size()), '0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
